// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU op codes and control-bundle bit positions.
package cpu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned CTL_W   = 5;

    // ALU op codes; any other code passes src1 through
    localparam logic [3:0] AluAnd = 4'b0111;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0011;
    localparam logic [3:0] AluSlt = 4'b0100;
    localparam logic [3:0] AluXor = 4'b0101;
    localparam logic [3:0] AluSll = 4'b0110;

    // Bit positions in the {reg_write, mem_read, mem_write, mem_to_reg, branch} bundle
    localparam int unsigned CtlRegWrite = 4;
    localparam int unsigned CtlMemRead  = 3;
    localparam int unsigned CtlMemWrite = 2;
    localparam int unsigned CtlMemToReg = 1;
    localparam int unsigned CtlBranch   = 0;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: EX/MEM beats MEM/WB beats the registered read data.
module fwd_mux #(
    parameter int unsigned XLEN    = cpu_pkg::XLEN,
    parameter int unsigned RADDR_W = cpu_pkg::RADDR_W
) (
    input  logic [RADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]    reg_data_i,
    input  logic               exmem_reg_write_i,
    input  logic [RADDR_W-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]    exmem_data_i,
    input  logic               memwb_reg_write_i,
    input  logic [RADDR_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]    memwb_data_i,
    output logic [XLEN-1:0]    data_o
);

    logic exmem_hit;
    logic memwb_hit;

    // x0 is hardwired, so a write to it must never be forwarded
    assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == addr_i);
    assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == addr_i);

    always_comb begin
        data_o = reg_data_i;
        if (exmem_hit) begin
            data_o = exmem_data_i;
        end else if (memwb_hit) begin
            data_o = memwb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard detection and ALU operand selection.
// Define ID_EX_FWD_EN to enable EX/MEM and MEM/WB forwarding; otherwise hazards stall.
module id_ex_stage #(
    parameter int unsigned XLEN    = cpu_pkg::XLEN,
    parameter int unsigned RADDR_W = cpu_pkg::RADDR_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               dec_valid_i,
    input  logic [XLEN-1:0]    dec_pc_i,
    input  logic [XLEN-1:0]    dec_rs1_data_i,
    input  logic [XLEN-1:0]    dec_rs2_data_i,
    input  logic [XLEN-1:0]    dec_imm_i,
    input  logic [RADDR_W-1:0] dec_rs1_i,
    input  logic [RADDR_W-1:0] dec_rs2_i,
    input  logic [RADDR_W-1:0] dec_rd_i,
    input  logic               dec_use_rs1_i,
    input  logic               dec_use_rs2_i,
    input  logic [3:0]         dec_alu_ctrl_i,
    input  logic               dec_alu_src_i,
    input  logic               dec_pc_src0_i,
    input  logic [4:0]         dec_ctl_i,
    input  logic               flush_i,
    input  logic               exmem_reg_write_i,
    input  logic [RADDR_W-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]    exmem_data_i,
    input  logic               memwb_reg_write_i,
    input  logic [RADDR_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]    memwb_data_i,
    output logic               stall_o,
    output logic               valid_o,
    output logic [XLEN-1:0]    src0_o,
    output logic [XLEN-1:0]    src1_o,
    output logic [3:0]         alu_ctrl_o,
    output logic [XLEN-1:0]    store_data_o,
    output logic [RADDR_W-1:0] rd_o,
    output logic [4:0]         ctl_o,
    output logic [XLEN-1:0]    pc_o,
    output logic [XLEN-1:0]    imm_o
);

    import cpu_pkg::*;

    logic               valid_q;
    logic [CTL_W-1:0]   ctl_q;
    logic [RADDR_W-1:0] rd_q;
    logic [RADDR_W-1:0] rs1_q;
    logic [RADDR_W-1:0] rs2_q;
    logic [3:0]         alu_ctrl_q;
    logic               alu_src_q;
    logic               pc_src0_q;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    imm_q;
    logic [XLEN-1:0]    rs1_data_q;
    logic [XLEN-1:0]    rs2_data_q;

    logic               load_use;
    logic               hazard;
    logic               bubble;
    logic [XLEN-1:0]    fwd_rs1;
    logic [XLEN-1:0]    fwd_rs2;

    assign load_use = valid_q && ctl_q[CtlMemRead] && (rd_q != '0) && dec_valid_i &&
                      ((dec_use_rs1_i && (dec_rs1_i == rd_q)) ||
                       (dec_use_rs2_i && (dec_rs2_i == rd_q)));

`ifdef ID_EX_FWD_EN
    assign hazard = load_use;

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
        .addr_i            (rs1_q),
        .reg_data_i        (rs1_data_q),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .exmem_data_i      (exmem_data_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .memwb_data_i      (memwb_data_i),
        .data_o            (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
        .addr_i            (rs2_q),
        .reg_data_i        (rs2_data_q),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .exmem_data_i      (exmem_data_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .memwb_data_i      (memwb_data_i),
        .data_o            (fwd_rs2)
    );
`else
    logic rs1_pending;
    logic rs2_pending;
    logic unused_fwd;

    // Without forwarding, wait until the producer leaves EX/MEM; the register file covers MEM/WB
    assign rs1_pending = dec_use_rs1_i && (dec_rs1_i != '0) &&
                         ((valid_q && ctl_q[CtlRegWrite] && (dec_rs1_i == rd_q)) ||
                          (exmem_reg_write_i && (dec_rs1_i == exmem_rd_i)));
    assign rs2_pending = dec_use_rs2_i && (dec_rs2_i != '0) &&
                         ((valid_q && ctl_q[CtlRegWrite] && (dec_rs2_i == rd_q)) ||
                          (exmem_reg_write_i && (dec_rs2_i == exmem_rd_i)));
    assign hazard      = load_use || (dec_valid_i && (rs1_pending || rs2_pending));

    assign fwd_rs1    = rs1_data_q;
    assign fwd_rs2    = rs2_data_q;
    assign unused_fwd = ^{exmem_data_i, memwb_reg_write_i, memwb_rd_i, memwb_data_i,
                          rs1_q, rs2_q};
`endif

    assign stall_o = hazard && !flush_i;
    assign bubble  = flush_i || hazard;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q    <= 1'b0;
            ctl_q      <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            alu_ctrl_q <= AluAdd;
            alu_src_q  <= 1'b0;
            pc_src0_q  <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else if (bubble) begin
            // Zeroed operands with ADD give a deterministic ALU result of 0
            valid_q    <= 1'b0;
            ctl_q      <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            alu_ctrl_q <= AluAdd;
            alu_src_q  <= 1'b0;
            pc_src0_q  <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            valid_q    <= dec_valid_i;
            ctl_q      <= dec_ctl_i;
            rd_q       <= dec_rd_i;
            rs1_q      <= dec_rs1_i;
            rs2_q      <= dec_rs2_i;
            alu_ctrl_q <= dec_alu_ctrl_i;
            alu_src_q  <= dec_alu_src_i;
            pc_src0_q  <= dec_pc_src0_i;
            pc_q       <= dec_pc_i;
            imm_q      <= dec_imm_i;
            rs1_data_q <= dec_rs1_data_i;
            rs2_data_q <= dec_rs2_data_i;
        end
    end

    assign valid_o      = valid_q;
    assign ctl_o        = ctl_q;
    assign rd_o         = rd_q;
    assign alu_ctrl_o   = alu_ctrl_q;
    assign pc_o         = pc_q;
    assign imm_o        = imm_q;
    assign src0_o       = pc_src0_q ? pc_q : fwd_rs1;
    assign src1_o       = alu_src_q ? imm_q : fwd_rs2;
    assign store_data_o = fwd_rs2;

endmodule
